// File: rtl/i2c_config_pkg.sv
// rtl/i2c_config_pkg.sv - shared state encoding and table constants for the I2C configuration sequencer
//
// Purpose: types and constants imported by i2c_config_sequencer and i2c_delay_timer.
// Ports: none (package).
package i2c_config_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    DECODE,
    WR_ISSUE,
    WR_ACCEPT,
    WR_WAIT,
    RD_ISSUE,
    RD_ACCEPT,
    RD_WAIT,
    FAIL,
    DELAY,
    NEXT,
    DONE,
    ERROR
  } state_t;

  // Table word that terminates the sequence early.
  localparam logic [15:0] END_MARKER = 16'hFFFF;
  // Register byte that turns an entry into a delay of data * DELAY_UNIT_US.
  localparam logic [7:0]  DELAY_REG  = 8'hFE;

  // clog2 that never returns 0, so degenerate parameters still give legal vector widths.
  function automatic int safe_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/i2c_delay_timer.sv
// rtl/i2c_delay_timer.sv - microsecond prescaler plus unit down-counter for table delay entries
//
// Purpose: after load, counts count * DELAY_UNIT_US microseconds of clock time.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   load     in   one-cycle pulse; latches count and restarts the prescaler
//   count    in   8-bit delay in DELAY_UNIT_US units
//   expired  out  high while no delay is pending (immediately after loading count=0)
module i2c_delay_timer
  import i2c_config_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 12000000,
  parameter int DELAY_UNIT_US   = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] count,
  output logic       expired
);

  localparam int CYCLES_PER_US = CLOCK_FREQUENCY / 1000000;
  localparam int PRE_W         = safe_clog2(CYCLES_PER_US);
  localparam int US_W          = safe_clog2(255 * DELAY_UNIT_US + 1);

  logic [PRE_W-1:0] prescale;
  logic [US_W-1:0]  remaining_us;

  // The prescaler only runs while microseconds remain, so an expired timer is fully idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale     <= '0;
      remaining_us <= '0;
    end else if (load) begin
      prescale     <= '0;
      remaining_us <= US_W'(int'(count) * DELAY_UNIT_US);
    end else if (remaining_us != '0) begin
      if (prescale == PRE_W'(CYCLES_PER_US - 1)) begin
        prescale     <= '0;
        remaining_us <= remaining_us - US_W'(1);
      end else begin
        prescale <= prescale + PRE_W'(1);
      end
    end
  end

  assign expired = (remaining_us == '0);

endmodule

// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks a {register, data} ROM table and drives a single-byte I2C master
//
// Purpose: register-initialisation sequencer with retries, optional readback verify,
// inline delay entries and an end marker.
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   start                     one-cycle pulse; restarts the table from entry 0 (IDLE/DONE/ERROR only)
//   busy, done, error         status levels
//   errorIndex                failing entry index, valid while error=1
//   tableAddress, tableData   synchronous ROM interface, data one cycle after address
//   i2cStartWrite/Read        one-cycle start pulses to the master
//   i2cAddress                constant DEVICE_ADDRESS
//   i2cRegister, i2cData      register and write-data bytes, stable across a transaction
//   i2cDataOut                read result from the master
//   i2cBusy, i2cAckError      master status; the ack flag is valid when busy falls
module i2c_config_sequencer
  import i2c_config_pkg::*;
#(
  parameter int         CLOCK_FREQUENCY = 12000000,
  parameter int         NR_OF_ENTRIES   = 64,
  parameter logic [6:0] DEVICE_ADDRESS  = 7'h21,
  parameter int         MAX_RETRIES     = 3,
  parameter int         VERIFY_WRITES   = 0,
  parameter int         DELAY_UNIT_US   = 1000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [safe_clog2(NR_OF_ENTRIES)-1:0]  errorIndex,
  output logic [safe_clog2(NR_OF_ENTRIES)-1:0]  tableAddress,
  input  logic [15:0]                           tableData,
  output logic                                  i2cStartWrite,
  output logic                                  i2cStartRead,
  output logic [6:0]                            i2cAddress,
  output logic [7:0]                            i2cRegister,
  output logic [7:0]                            i2cData,
  input  logic [7:0]                            i2cDataOut,
  input  logic                                  i2cBusy,
  input  logic                                  i2cAckError
);

  localparam int IDX_W   = safe_clog2(NR_OF_ENTRIES);
  localparam int RETRY_W = safe_clog2(MAX_RETRIES + 1);

  localparam logic [IDX_W-1:0]   LAST_INDEX  = IDX_W'(NR_OF_ENTRIES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     index;
  logic [RETRY_W-1:0]   retry_count;
  logic                 start_accept;
  logic                 delay_load;
  logic                 delay_expired;

  assign start_accept = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Entry index, retry count and the captured table word. i2cRegister/i2cData only
  // change in LOAD, which keeps them stable across every retry of an entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      index       <= '0;
      retry_count <= '0;
      errorIndex  <= '0;
      i2cRegister <= '0;
      i2cData     <= '0;
    end else begin
      if (start_accept) begin
        index       <= '0;
        retry_count <= '0;
      end
      case (state)
        LOAD: begin
          i2cRegister <= tableData[15:8];
          i2cData     <= tableData[7:0];
        end
        FAIL: begin
          if (retry_count < RETRY_LIMIT) begin
            retry_count <= retry_count + RETRY_W'(1);
          end else begin
            errorIndex <= index;
          end
        end
        NEXT: begin
          retry_count <= '0;
          // The last entry ends the walk; the index is never wrapped.
          if (index != LAST_INDEX) begin
            index <= index + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    i2cStartWrite = 1'b0;
    i2cStartRead  = 1'b0;
    delay_load    = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: state_next = LOAD;
      LOAD:  state_next = DECODE;
      DECODE: begin
        if ({i2cRegister, i2cData} == END_MARKER) begin
          state_next = DONE;
        end else if (i2cRegister == DELAY_REG) begin
          delay_load = 1'b1;
          state_next = DELAY;
        end else begin
          state_next = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        i2cStartWrite = 1'b1;
        state_next    = WR_ACCEPT;
      end
      // The master raises busy a cycle after the pulse; waiting for it here keeps
      // WR_WAIT from mistaking the pre-start idle for a finished transfer.
      WR_ACCEPT: begin
        if (i2cBusy) begin
          state_next = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (!i2cBusy) begin
          if (i2cAckError) begin
            state_next = FAIL;
          end else if (VERIFY_WRITES != 0) begin
            state_next = RD_ISSUE;
          end else begin
            state_next = NEXT;
          end
        end
      end
      RD_ISSUE: begin
        i2cStartRead = 1'b1;
        state_next   = RD_ACCEPT;
      end
      RD_ACCEPT: begin
        if (i2cBusy) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!i2cBusy) begin
          if (i2cAckError || (i2cDataOut != i2cData)) begin
            state_next = FAIL;
          end else begin
            state_next = NEXT;
          end
        end
      end
      FAIL: begin
        if (retry_count < RETRY_LIMIT) begin
          state_next = WR_ISSUE;
        end else begin
          state_next = ERROR;
        end
      end
      DELAY: begin
        if (delay_expired) begin
          state_next = NEXT;
        end
      end
      NEXT: begin
        if (index == LAST_INDEX) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  i2c_delay_timer #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .DELAY_UNIT_US  (DELAY_UNIT_US)
  ) u_delay_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (delay_load),
    .count  (i2cData),
    .expired(delay_expired)
  );

  assign busy         = !((state == IDLE) || (state == DONE) || (state == ERROR));
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign tableAddress = index;
  assign i2cAddress   = DEVICE_ADDRESS;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb/tb_i2c_config_sequencer.sv - self-checking bench for i2c_config_sequencer
module tb_i2c_config_sequencer;

  localparam int NR   = 8;
  localparam int MAXR = 3;

  typedef struct {
    bit       rd;
    bit [7:0] rg;
    bit [7:0] dt;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start       [2];
  logic        busy        [2];
  logic        done        [2];
  logic        error       [2];
  logic [2:0]  error_index [2];
  logic [2:0]  table_addr  [2];
  logic [15:0] table_data  [2];
  logic        start_write [2];
  logic        start_read  [2];
  logic [6:0]  dev_addr    [2];
  logic [7:0]  reg_byte    [2];
  logic [7:0]  data_byte   [2];
  logic [7:0]  data_out    [2];
  logic        m_busy      [2];
  logic        m_ack_err   [2];

  always #5 clock = ~clock;

  i2c_config_sequencer #(
    .CLOCK_FREQUENCY(12000000), .NR_OF_ENTRIES(NR), .DEVICE_ADDRESS(7'h21),
    .MAX_RETRIES(MAXR), .VERIFY_WRITES(0), .DELAY_UNIT_US(10)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .errorIndex(error_index[0]), .tableAddress(table_addr[0]),
    .tableData(table_data[0]), .i2cStartWrite(start_write[0]), .i2cStartRead(start_read[0]),
    .i2cAddress(dev_addr[0]), .i2cRegister(reg_byte[0]), .i2cData(data_byte[0]),
    .i2cDataOut(data_out[0]), .i2cBusy(m_busy[0]), .i2cAckError(m_ack_err[0])
  );

  i2c_config_sequencer #(
    .CLOCK_FREQUENCY(12000000), .NR_OF_ENTRIES(NR), .DEVICE_ADDRESS(7'h3C),
    .MAX_RETRIES(MAXR), .VERIFY_WRITES(1), .DELAY_UNIT_US(10)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .errorIndex(error_index[1]), .tableAddress(table_addr[1]),
    .tableData(table_data[1]), .i2cStartWrite(start_write[1]), .i2cStartRead(start_read[1]),
    .i2cAddress(dev_addr[1]), .i2cRegister(reg_byte[1]), .i2cData(data_byte[1]),
    .i2cDataOut(data_out[1]), .i2cBusy(m_busy[1]), .i2cAckError(m_ack_err[1])
  );

  bit [15:0] rom        [2][NR];
  int        nack_init  [2][256];
  int        nack_left  [2][256];
  bit [7:0]  mem        [2][256];
  int        corrupt_reg[2];
  bit [7:0]  corrupt_val[2];
  txn_t      got_q      [2][$];
  txn_t      exp_q      [$];
  int        gap_q      [2][$];
  int        last_end   [2];
  bit        pend       [2];
  bit        active     [2];
  bit        pend_rd    [2];
  bit [7:0]  cap_reg    [2];
  bit [7:0]  cap_dat    [2];
  int        left_cyc   [2];
  int        cyc = 0;
  int        vectors;
  int        miscompares;
  int        base_gap;

  always @(posedge clock) cyc++;

  // Synchronous ROM plus a behavioural single-byte I2C master/slave pair, evaluated
  // on the falling edge so the DUT sees stable inputs at its rising edge.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      table_data[k] = rom[k][table_addr[k]];
      if (reset) begin
        m_busy[k] = 1'b0; m_ack_err[k] = 1'b0; data_out[k] = 8'h00;
        pend[k] = 1'b0; active[k] = 1'b0;
      end else if (start_write[k] || start_read[k]) begin
        txn_t t;
        vectors++;
        if ((start_write[k] && start_read[k]) || m_busy[k] || pend[k] || active[k]) begin
          miscompares++;
          $display("FAIL start_overlap dut%0d: write=%0b read=%0b master_busy=%0b, required lone pulse while idle",
                   k, start_write[k], start_read[k], m_busy[k]);
        end
        pend[k] = 1'b1; pend_rd[k] = start_read[k];
        cap_reg[k] = reg_byte[k]; cap_dat[k] = data_byte[k];
        t.rd = start_read[k]; t.rg = reg_byte[k]; t.dt = data_byte[k];
        got_q[k].push_back(t);
        gap_q[k].push_back(cyc - last_end[k]);
      end else if (pend[k]) begin
        pend[k] = 1'b0; active[k] = 1'b1; m_busy[k] = 1'b1; m_ack_err[k] = 1'b0;
        left_cyc[k] = $urandom_range(1, 4);
      end else if (active[k]) begin
        vectors++;
        if (reg_byte[k] !== cap_reg[k] || data_byte[k] !== cap_dat[k]) begin
          miscompares++;
          $display("FAIL hold_stable dut%0d: got %02h/%02h required %02h/%02h",
                   k, reg_byte[k], data_byte[k], cap_reg[k], cap_dat[k]);
        end
        if (left_cyc[k] == 0) begin
          active[k] = 1'b0; m_busy[k] = 1'b0; last_end[k] = cyc;
          if (pend_rd[k]) begin
            m_ack_err[k] = 1'b0;
            data_out[k] = (corrupt_reg[k] == int'(cap_reg[k])) ? corrupt_val[k] : mem[k][cap_reg[k]];
          end else if (nack_left[k][cap_reg[k]] > 0) begin
            m_ack_err[k] = 1'b1;
            nack_left[k][cap_reg[k]]--;
          end else begin
            m_ack_err[k] = 1'b0;
            mem[k][cap_reg[k]] = cap_dat[k];
          end
        end else begin
          left_cyc[k]--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_slave(input int k);
    for (int r = 0; r < 256; r++) begin
      nack_init[k][r] = 0; nack_left[k][r] = 0; mem[k][r] = 8'h00;
    end
    corrupt_reg[k] = -1; corrupt_val[k] = 8'h00;
  endtask

  task automatic set_nack(input int k, input int rg, input int n);
    nack_init[k][rg] = n; nack_left[k][rg] = n;
  endtask

  task automatic load_table(input int k, input bit [15:0] words[$]);
    for (int i = 0; i < NR; i++) rom[k][i] = (i < words.size()) ? words[i] : 16'hFFFF;
  endtask

  // Reference: walk the table with the retry/verify rules at transaction granularity.
  task automatic build_expected(input int k, output bit exp_err, output int exp_idx);
    int nl[256];
    for (int r = 0; r < 256; r++) nl[r] = nack_init[k][r];
    exp_q.delete(); exp_err = 1'b0; exp_idx = 0;
    for (int idx = 0; idx < NR; idx++) begin
      bit [15:0] w;
      bit ok;
      w = rom[k][idx];
      ok = 1'b0;
      if (w == 16'hFFFF) return;
      if (w[15:8] == 8'hFE) continue;
      for (int a = 0; a <= MAXR && !ok; a++) begin
        txn_t t;
        t.rd = 1'b0; t.rg = w[15:8]; t.dt = w[7:0];
        exp_q.push_back(t);
        if (nl[w[15:8]] > 0) begin
          nl[w[15:8]]--;
          continue;
        end
        if (k == 1) begin
          t.rd = 1'b1;
          exp_q.push_back(t);
          if (corrupt_reg[k] == int'(w[15:8]) && corrupt_val[k] != w[7:0]) continue;
        end
        ok = 1'b1;
      end
      if (!ok) begin
        exp_err = 1'b1; exp_idx = idx;
        return;
      end
    end
  endtask

  function automatic int txn_diff(input int k);
    int n;
    n = (got_q[k].size() < exp_q.size()) ? got_q[k].size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[k][i].rd != exp_q[i].rd || got_q[k][i].rg != exp_q[i].rg || got_q[k][i].dt != exp_q[i].dt)
        return i;
    end
    return (got_q[k].size() == exp_q.size()) ? -1 : n;
  endfunction

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clock);
    start[k] = 1'b0;
  endtask

  task automatic wait_finish(input int k, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done[k] || error[k]) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_seq(input int k, output bit timed_out, output bit exp_err, output int exp_idx);
    build_expected(k, exp_err, exp_idx);
    got_q[k].delete(); gap_q[k].delete();
    pulse_start(k);
    wait_finish(k, 6000, timed_out);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({busy[k], done[k], error[k], start_write[k], start_read[k]} !== 5'b0 ||
          table_addr[k] !== 3'd0 || error_index[k] !== 3'd0 || reg_byte[k] !== 8'h00 || data_byte[k] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d: busy=%0b done=%0b error=%0b addr=%0d eidx=%0d reg=%02h dat=%02h, required all zero",
                 k, busy[k], done[k], error[k], table_addr[k], error_index[k], reg_byte[k], data_byte[k]);
      end
    end
    vectors++;
    if (dev_addr[0] !== 7'h21 || dev_addr[1] !== 7'h3C) begin
      miscompares++;
      $display("FAIL device_address: got %02h/%02h required 21/3c", dev_addr[0], dev_addr[1]);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    bit to, ee; int ei;
    clear_slave(0);
    load_table(0, '{16'h1280, 16'h1101, 16'hFFFF});
    build_expected(0, ee, ei);
    got_q[0].delete(); gap_q[0].delete();
    pulse_start(0);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_after_start: got %0b required 1", busy[0]);
    end
    wait_finish(0, 2000, to);
    vectors++;
    if (to || txn_diff(0) != -1 || got_q[0].size() != 2) begin
      miscompares++; $display("FAIL basic_txns: timeout=%0b diff_at=%0d count=%0d required 2 writes in order", to, txn_diff(0), got_q[0].size());
    end
    vectors++;
    if ({done[0], error[0], busy[0]} !== 3'b100) begin
      miscompares++; $display("FAIL basic_status: done/error/busy=%b required 100", {done[0], error[0], busy[0]});
    end
    base_gap = (gap_q[0].size() > 1) ? gap_q[0][1] : 0;
  endtask

  task automatic test_retry_recover();
    bit to, ee; int ei; int n11;
    clear_slave(0);
    set_nack(0, 8'h11, 2);
    load_table(0, '{16'h1280, 16'h1101, 16'hFFFF});
    run_seq(0, to, ee, ei);
    n11 = 0;
    foreach (got_q[0][i]) if (got_q[0][i].rg == 8'h11 && got_q[0][i].dt == 8'h01) n11++;
    vectors++;
    if (to || txn_diff(0) != -1 || n11 != 3) begin
      miscompares++; $display("FAIL retry_recover_txns: timeout=%0b diff_at=%0d writes_11=%0d required 3", to, txn_diff(0), n11);
    end
    vectors++;
    if ({done[0], error[0]} !== 2'b10) begin
      miscompares++; $display("FAIL retry_recover_status: done/error=%b required 10", {done[0], error[0]});
    end
  endtask

  task automatic test_retry_error();
    bit to, ee; int ei;
    clear_slave(0);
    set_nack(0, 8'h30, 1000);
    load_table(0, '{16'h1011, 16'h2022, 16'h3033, 16'hFFFF});
    run_seq(0, to, ee, ei);
    vectors++;
    if (to || txn_diff(0) != -1 || got_q[0].size() != 6) begin
      miscompares++; $display("FAIL retry_error_txns: timeout=%0b diff_at=%0d count=%0d required 6", to, txn_diff(0), got_q[0].size());
    end
    vectors++;
    if ({done[0], error[0], busy[0]} !== 3'b010 || error_index[0] !== 3'd2) begin
      miscompares++; $display("FAIL retry_error_status: done/error/busy=%b eidx=%0d required 010 and 2",
                              {done[0], error[0], busy[0]}, error_index[0]);
    end
    set_nack(0, 8'h30, 0);
    build_expected(0, ee, ei);
    got_q[0].delete();
    pulse_start(0);
    vectors++;
    if (error[0] !== 1'b0 || busy[0] !== 1'b1) begin
      miscompares++; $display("FAIL restart_clears_error: error=%0b busy=%0b required 0 1", error[0], busy[0]);
    end
    wait_finish(0, 2000, to);
    vectors++;
    if (to || txn_diff(0) != -1 || done[0] !== 1'b1) begin
      miscompares++; $display("FAIL restart_from_zero: timeout=%0b diff_at=%0d done=%0b required full rerun", to, txn_diff(0), done[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    clear_slave(0);
    load_table(0, '{16'h1280, 16'h1101, 16'hFFFF});
    got_q[0].delete();
    pulse_start(0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (m_busy[0]) seen = 1'b1;
      else @(negedge clock);
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL reset_mid_reach_wait: master busy=%0b required 1 within 50 cycles", m_busy[0]);
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({busy[0], done[0], error[0], start_write[0], start_read[0]} !== 5'b0 || table_addr[0] !== 3'd0 ||
        error_index[0] !== 3'd0 || reg_byte[0] !== 8'h00 || data_byte[0] !== 8'h00) begin
      miscompares++; $display("FAIL reset_mid_outputs: busy=%0b done=%0b error=%0b eidx=%0d reg=%02h required all zero",
                              busy[0], done[0], error[0], error_index[0], reg_byte[0]);
    end
    reset = 1'b0;
    n = got_q[0].size();
    tick(30);
    vectors++;
    if (got_q[0].size() != n || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_quiet: new_txns=%0d busy=%0b done=%0b required 0 0 0", got_q[0].size() - n, busy[0], done[0]);
    end
  endtask

  task automatic test_delay();
    bit to, ee; int ei;
    clear_slave(0);
    load_table(0, '{16'h1280, 16'hFE02, 16'h1101, 16'hFE00, 16'h1305, 16'hFFFF});
    run_seq(0, to, ee, ei);
    vectors++;
    if (to || txn_diff(0) != -1 || done[0] !== 1'b1) begin
      miscompares++; $display("FAIL delay_txns: timeout=%0b diff_at=%0d done=%0b required 3 writes then done", to, txn_diff(0), done[0]);
    end
    vectors++;
    if (gap_q[0].size() < 3 || gap_q[0][1] < 240 || gap_q[0][1] > base_gap + 260) begin
      miscompares++; $display("FAIL delay_two_units: gap=%0d required 240..%0d", (gap_q[0].size() > 1) ? gap_q[0][1] : -1, base_gap + 260);
    end
    vectors++;
    if (gap_q[0].size() < 3 || gap_q[0][2] < base_gap + 1 || gap_q[0][2] > base_gap + 5) begin
      miscompares++; $display("FAIL delay_zero: gap=%0d required %0d..%0d", (gap_q[0].size() > 2) ? gap_q[0][2] : -1, base_gap + 1, base_gap + 5);
    end
  endtask

  task automatic test_verify();
    bit to, ee; int ei;
    clear_slave(1);
    corrupt_reg[1] = 8'h12; corrupt_val[1] = 8'h7F;
    load_table(1, '{16'h1280, 16'hFFFF});
    run_seq(1, to, ee, ei);
    vectors++;
    if (to || txn_diff(1) != -1 || got_q[1].size() != 8) begin
      miscompares++; $display("FAIL verify_mismatch_txns: timeout=%0b diff_at=%0d count=%0d required 8", to, txn_diff(1), got_q[1].size());
    end
    vectors++;
    if (error[1] !== 1'b1 || error_index[1] !== 3'd0) begin
      miscompares++; $display("FAIL verify_mismatch_status: error=%0b eidx=%0d required 1 0", error[1], error_index[1]);
    end
    corrupt_val[1] = 8'h80;
    run_seq(1, to, ee, ei);
    vectors++;
    if (to || txn_diff(1) != -1 || done[1] !== 1'b1) begin
      miscompares++; $display("FAIL verify_match: timeout=%0b diff_at=%0d done=%0b required write+read then done", to, txn_diff(1), done[1]);
    end
  endtask

  task automatic test_implicit_end();
    bit to, ee; int ei;
    bit [15:0] words[$];
    clear_slave(0);
    for (int i = 0; i < NR; i++) words.push_back(16'(16'h4000 + i * 16'h0101));
    load_table(0, words);
    run_seq(0, to, ee, ei);
    vectors++;
    if (to || txn_diff(0) != -1 || got_q[0].size() != NR || done[0] !== 1'b1) begin
      miscompares++; $display("FAIL implicit_end: timeout=%0b count=%0d done=%0b required %0d writes then done", to, got_q[0].size(), done[0], NR);
    end
  endtask

  task automatic test_start_ignored();
    bit to, ee; int ei;
    logic [2:0] addr_before;
    clear_slave(0);
    set_nack(0, 8'h21, 1);
    load_table(0, '{16'h20AA, 16'h2155, 16'h2233, 16'hFFFF});
    build_expected(0, ee, ei);
    got_q[0].delete();
    pulse_start(0);
    for (int i = 0; i < 200 && !(m_busy[0] && got_q[0].size() >= 2); i++) @(negedge clock);
    addr_before = table_addr[0];
    pulse_start(0);
    vectors++;
    if (table_addr[0] !== addr_before || busy[0] !== 1'b1) begin
      miscompares++; $display("FAIL start_while_busy_index: addr=%0d busy=%0b required %0d 1", table_addr[0], busy[0], addr_before);
    end
    wait_finish(0, 2000, to);
    vectors++;
    if (to || txn_diff(0) != -1 || done[0] !== 1'b1) begin
      miscompares++; $display("FAIL start_while_busy_seq: timeout=%0b diff_at=%0d done=%0b required uninterrupted run", to, txn_diff(0), done[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int k;
      bit to, ee; int ei;
      bit [15:0] words[$];
      k = it % 2;
      clear_slave(k);
      for (int idx = 0; idx < NR; idx++) begin
        int r;
        bit [7:0] rg, dt;
        r = $urandom_range(0, 11);
        rg = 8'(16 * idx + $urandom_range(0, 15));
        dt = 8'($urandom_range(0, 255));
        if (r == 0) words.push_back(16'hFFFF);
        else if (r == 1) words.push_back({8'hFE, 8'($urandom_range(0, 1))});
        else begin
          words.push_back({rg, dt});
          if ($urandom_range(0, 9) > 6) set_nack(k, rg, $urandom_range(1, 4));
          if (k == 1 && $urandom_range(0, 5) == 0) begin
            corrupt_reg[1] = rg;
            corrupt_val[1] = $urandom_range(0, 1) ? dt : (dt ^ 8'h01);
          end
        end
      end
      load_table(k, words);
      run_seq(k, to, ee, ei);
      vectors++;
      if (to || txn_diff(k) != -1) begin
        miscompares++; $display("FAIL random_%0d_txns dut%0d: timeout=%0b diff_at=%0d got=%0d required=%0d",
                                it, k, to, txn_diff(k), got_q[k].size(), exp_q.size());
      end
      vectors++;
      if (done[k] !== !ee || error[k] !== ee || (ee && error_index[k] !== 3'(ei))) begin
        miscompares++; $display("FAIL random_%0d_status dut%0d: done=%0b error=%0b eidx=%0d required error=%0b eidx=%0d",
                                it, k, done[k], error[k], error_index[k], ee, ei);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    vectors = 0; miscompares = 0; base_gap = 0;
    last_end[0] = 0; last_end[1] = 0;
    clear_slave(0); clear_slave(1);
    load_table(0, '{16'hFFFF}); load_table(1, '{16'hFFFF});
    test_reset();
    test_basic();
    test_retry_recover();
    test_retry_error();
    test_reset_mid();
    test_delay();
    test_verify();
    test_implicit_end();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
